// File: rtl/fbuff_mem_ctrl_if.sv
// Frame buffer controller bus: row-read request/response (pulse/pulse),
// row-write request/acknowledge (level/pulse) and the sticky error flags.
interface fbuff_mem_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 60
);

  logic              fbuff_rd_req_i;
  logic [ADDR_W-1:0] fbuff_addra_i;
  logic [DATA_W-1:0] fbuff_data_o;
  logic              fbuff_rd_rsp_o;
  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ack_o;
  logic [1:0]        err_o;

  // Requester side: line buffer fill logic and pixel writer
  modport master (
    output fbuff_rd_req_i, fbuff_addra_i, wr_req_i, wr_addr_i, wr_data_i,
    input  fbuff_data_o, fbuff_rd_rsp_o, wr_ack_o, err_o
  );

  // Responder side: the frame buffer controller
  modport slave (
    input  fbuff_rd_req_i, fbuff_addra_i, wr_req_i, wr_addr_i, wr_data_i,
    output fbuff_data_o, fbuff_rd_rsp_o, wr_ack_o, err_o
  );

endinterface

// File: rtl/fbuff_mem_ctrl.sv
// Frame buffer responder. Owns the single-port frame buffer RAM and
// serialises row reads (line buffer fill) and row writes (pixel source)
// through one FSM. Reads take priority; a read arriving while busy is
// parked in a one-deep pending slot, a further one is dropped and flagged.

// Single-port RAM with registered output, 1 or 2 cycles read latency.
module xilinx_single_port_ram #(
  parameter int    RAM_WIDTH     = 60,
  parameter int    RAM_DEPTH     = 4800,
  parameter int    RAM_ADDR_BITS = 13,
  parameter int    RD_LATENCY    = 1,
  parameter string INIT_FILE     = ""
) (
  input  logic                     clka,
  input  logic [RAM_ADDR_BITS-1:0] addra,
  input  logic [RAM_WIDTH-1:0]     dina,
  input  logic                     wea,
  input  logic                     ena,
  output logic [RAM_WIDTH-1:0]     douta
);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] rd_q;

  // Array write or registered read; no read data update on a write cycle
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) begin
        mem_q[addra] <= dina;
      end else begin
        rd_q <= mem_q[addra];
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [RAM_WIDTH-1:0] pipe_q;

    // Second output register stage for the two-cycle configuration
    always_ff @(posedge clka) begin
      pipe_q <= rd_q;
    end

    assign douta = pipe_q;
  end else begin : g_lat1
    assign douta = rd_q;
  end

  // Preload content is attached by the vendor implementation flow
  if (INIT_FILE != "") begin : g_init_hook
  end

endmodule

module fbuff_mem_ctrl #(
  parameter int    FBUFF_DEPTH      = 4800,
  parameter int    FBUFF_ADDR_WIDTH = 13,
  parameter int    FBUFF_DATA_WIDTH = 60,
  parameter int    RD_LATENCY       = 1,
  parameter string INIT_FILE        = ""
) (
  input logic             clk_i,
  input logic             rstn_i,
  fbuff_mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RESPOND = 3'd2,
    ST_WRITE   = 3'd3,
    ST_ACK     = 3'd4
  } state_e;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);
  localparam logic [FBUFF_ADDR_WIDTH:0] DEPTH_EXT = (FBUFF_ADDR_WIDTH + 1)'(FBUFF_DEPTH);

  // Row address beyond the populated part of the RAM
  function automatic logic addr_oor(input logic [FBUFF_ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= DEPTH_EXT);
  endfunction

  state_e                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic                        rd_pend_q, rd_pend_d;
  logic [FBUFF_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                        rd_oor_q, rd_oor_d;
  logic [FBUFF_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [FBUFF_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [FBUFF_DATA_WIDTH-1:0] data_q, data_d;
  logic                        rsp_q, rsp_d;
  logic                        ack_q, ack_d;
  logic [1:0]                  err_q, err_d;

  logic                        ram_en_s;
  logic                        ram_we_s;
  logic [FBUFF_ADDR_WIDTH-1:0] ram_addr_s;
  logic [FBUFF_DATA_WIDTH-1:0] ram_dout_s;
  logic [FBUFF_ADDR_WIDTH-1:0] sel_addr_s;
  logic                        sel_oor_s;
  logic                        wr_oor_s;

  xilinx_single_port_ram #(
    .RAM_WIDTH    (FBUFF_DATA_WIDTH),
    .RAM_DEPTH    (FBUFF_DEPTH),
    .RAM_ADDR_BITS(FBUFF_ADDR_WIDTH),
    .RD_LATENCY   (RD_LATENCY),
    .INIT_FILE    (INIT_FILE)
  ) u_ram (
    .clka (clk_i),
    .addra(ram_addr_s),
    .dina (wr_data_q),
    .wea  (ram_we_s),
    .ena  (ram_en_s),
    .douta(ram_dout_s)
  );

  // Next-state, RAM control and registered-output next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    rd_oor_d   = rd_oor_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    data_d     = data_q;
    rsp_d      = 1'b0;
    ack_d      = 1'b0;
    err_d      = err_q;
    ram_en_s   = 1'b0;
    ram_we_s   = 1'b0;
    ram_addr_s = wr_addr_q;
    wr_oor_s   = addr_oor(wr_addr_q);
    sel_addr_s = rd_pend_q ? rd_addr_q : bus.fbuff_addra_i;
    sel_oor_s  = addr_oor(sel_addr_s);

    // Outside IDLE a new read is parked, unless a read is already owned
    if (state_q != ST_IDLE && bus.fbuff_rd_req_i) begin
      if (state_q == ST_READ || rd_pend_q) begin
        err_d[0] = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = bus.fbuff_addra_i;
      end
    end else begin
      rd_pend_d = rd_pend_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_pend_q || bus.fbuff_rd_req_i) begin
          if (rd_pend_q && bus.fbuff_rd_req_i) begin
            err_d[0] = 1'b1;
          end else begin
            err_d[0] = err_q[0];
          end
          if (sel_oor_s) begin
            err_d[1] = 1'b1;
          end else begin
            ram_en_s = 1'b1;
          end
          ram_addr_s = sel_addr_s;
          rd_oor_d   = sel_oor_s;
          rd_pend_d  = 1'b0;
          cnt_d      = LAT_LOAD;
          state_d    = ST_READ;
        end else if (bus.wr_req_i) begin
          wr_addr_d = bus.wr_addr_i;
          wr_data_d = bus.wr_data_i;
          state_d   = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_q == 2'd0) begin
          data_d  = rd_oor_q ? {FBUFF_DATA_WIDTH{1'b0}} : ram_dout_s;
          rsp_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESPOND: begin
        // Hand the port straight to a waiting write when no read is queued
        if (bus.wr_req_i && !rd_pend_q && !bus.fbuff_rd_req_i) begin
          wr_addr_d = bus.wr_addr_i;
          wr_data_d = bus.wr_data_i;
          state_d   = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_oor_s) begin
          err_d[1] = 1'b1;
        end else begin
          ram_en_s = 1'b1;
          ram_we_s = 1'b1;
        end
        ack_d   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; RAM contents are not affected by reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= {FBUFF_ADDR_WIDTH{1'b0}};
      rd_oor_q  <= 1'b0;
      wr_addr_q <= {FBUFF_ADDR_WIDTH{1'b0}};
      wr_data_q <= {FBUFF_DATA_WIDTH{1'b0}};
      data_q    <= {FBUFF_DATA_WIDTH{1'b0}};
      rsp_q     <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rd_oor_q  <= rd_oor_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      data_q    <= data_d;
      rsp_q     <= rsp_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.fbuff_data_o   = data_q;
  assign bus.fbuff_rd_rsp_o = rsp_q;
  assign bus.wr_ack_o       = ack_q;
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_fbuff_mem_ctrl.sv
// Directed bench for fbuff_mem_ctrl: one instance at RD_LATENCY=1 and one at
// RD_LATENCY=2 share the same stimulus; sel picks which one is observed.
`timescale 1ns/1ps
module tb_fbuff_mem_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 60;
  localparam int DEPTH = 4800;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  int            sel;
  int            total = 0;
  int            bad   = 0;

  logic          o_rsp;
  logic          o_ack;
  logic [DW-1:0] o_data;
  logic [1:0]    o_err;

  always #5 clk = ~clk;

  fbuff_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  fbuff_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  assign bus1.fbuff_rd_req_i = rd_req;
  assign bus1.fbuff_addra_i  = rd_addr;
  assign bus1.wr_req_i       = wr_req;
  assign bus1.wr_addr_i      = wr_addr;
  assign bus1.wr_data_i      = wr_data;
  assign bus2.fbuff_rd_req_i = rd_req;
  assign bus2.fbuff_addra_i  = rd_addr;
  assign bus2.wr_req_i       = wr_req;
  assign bus2.wr_addr_i      = wr_addr;
  assign bus2.wr_data_i      = wr_data;

  assign o_rsp  = (sel == 1) ? bus2.fbuff_rd_rsp_o : bus1.fbuff_rd_rsp_o;
  assign o_ack  = (sel == 1) ? bus2.wr_ack_o       : bus1.wr_ack_o;
  assign o_data = (sel == 1) ? bus2.fbuff_data_o   : bus1.fbuff_data_o;
  assign o_err  = (sel == 1) ? bus2.err_o          : bus1.err_o;

  fbuff_mem_ctrl #(
    .FBUFF_DEPTH(DEPTH), .FBUFF_ADDR_WIDTH(AW), .FBUFF_DATA_WIDTH(DW),
    .RD_LATENCY(1), .INIT_FILE("")
  ) dut1 (.clk_i(clk), .rstn_i(rstn), .bus(bus1));

  fbuff_mem_ctrl #(
    .FBUFF_DEPTH(DEPTH), .FBUFF_ADDR_WIDTH(AW), .FBUFF_DATA_WIDTH(DW),
    .RD_LATENCY(2), .INIT_FILE("")
  ) dut2 (.clk_i(clk), .rstn_i(rstn), .bus(bus2));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int r);
    logic [12:0] a;
    a = r[12:0];
    return {a ^ 13'h0AAA, 34'h2_5555_AAAA, a};
  endfunction

  // Write with held request; lat = cycle of ack counted from request cycle 0
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    lat = -1;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (o_ack) begin
        lat = i;
        wr_req = 1'b0;
      end
    end
    wr_req = 1'b0;
  endtask

  // One-cycle read pulse; lat = cycle of rsp counted from request cycle 0
  task automatic do_read(input logic [AW-1:0] a, output int lat, output logic [DW-1:0] d);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = a;
    lat = -1; d = '0;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 1) rd_req = 1'b0;
      if (o_rsp) begin
        lat = i;
        d = o_data;
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp_d, input int exp_lat);
    int            lat;
    logic [DW-1:0] d;
    do_read(a, lat, d);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_data"}, 64'(d), 64'(exp_d));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    int            rsp_c;
    int            ack_c;
    int            n;
    int            seen;
    logic [DW-1:0] d;
    logic [DW-1:0] v3;
    logic [DW-1:0] v4;
    logic [DW-1:0] v6;

    v3 = 60'hA5A_5A5_A5A_5A5_A5A;
    v4 = 60'h0F0_F0F_0F0_F0F_0F0;
    v6 = 60'hDEA_DBE_EFC_AFE_123;
    rstn = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data1", 64'(bus1.fbuff_data_o), 64'd0);
    check_eq("rst_rsp1",  64'(bus1.fbuff_rd_rsp_o), 64'd0);
    check_eq("rst_ack1",  64'(bus1.wr_ack_o), 64'd0);
    check_eq("rst_err1",  64'(bus1.err_o), 64'd0);
    check_eq("rst_rsp2",  64'(bus2.fbuff_rd_rsp_o), 64'd0);
    rstn = 1'b1;

    // 1: write row 0 then read it back
    do_write(13'd0, 60'h123_456_789_ABC_DEF, lat);
    check_eq("t1_ack_lat", 64'(lat), 64'd2);
    read_check("t1_rd", 13'd0, 60'h123_456_789_ABC_DEF, 2);
    @(negedge clk);
    check_eq("t1_rsp_pulse", 64'(o_rsp), 64'd0);
    check_eq("t1_data_held", 64'(o_data), 64'h0123_4567_89AB_CDEF);
    check_eq("t1_err", 64'(o_err), 64'd0);

    // 2: fill every row, then line-buffer style sweep 0..4799 and row 0 again
    for (int r = 0; r < DEPTH; r++) begin
      do_write(AW'(r), pat(r), lat);
      if (lat != 2) check_eq($sformatf("t2_wr_lat_%0d", r), 64'(lat), 64'd2);
    end
    n = 0;
    for (int r = 0; r <= DEPTH; r++) begin
      int row;
      row = (r == DEPTH) ? 0 : r;
      do_read(AW'(row), lat, d);
      if (lat >= 0) n++;
      check_eq($sformatf("t2_lat_%0d", r), 64'(lat), 64'd2);
      check_eq($sformatf("t2_data_%0d", r), 64'(d), 64'(pat(row)));
    end
    check_eq("t2_rsp_count", 64'(n), 64'd4801);

    // 3: read and write in the same IDLE cycle
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 13'd7;
    wr_req = 1'b1; wr_addr = 13'd10; wr_data = v3;
    rsp_c = -1; ack_c = -1; d = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) rd_req = 1'b0;
      if (o_rsp) begin rsp_c = c; d = o_data; end
      if (o_ack) begin ack_c = c; wr_req = 1'b0; end
    end
    wr_req = 1'b0;
    check_eq("t3_rsp_cyc", 64'(rsp_c), 64'd2);
    check_eq("t3_ack_cyc", 64'(ack_c), 64'd4);
    check_eq("t3_rd_data", 64'(d), 64'(pat(7)));
    read_check("t3_readback", 13'd10, v3, 2);

    // 4: read pulse during WRITE is held pending and serviced after ACK
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 13'd20; wr_data = v4;
    rsp_c = -1; ack_c = -1; d = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) begin rd_req = 1'b1; rd_addr = 13'd20; end
      if (c == 2) rd_req = 1'b0;
      if (o_rsp) begin rsp_c = c; d = o_data; end
      if (o_ack) begin ack_c = c; wr_req = 1'b0; end
    end
    check_eq("t4_ack_cyc", 64'(ack_c), 64'd2);
    check_eq("t4_rsp_cyc", 64'(rsp_c), 64'd5);
    check_eq("t4_rd_data", 64'(d), 64'(v4));
    check_eq("t4_err", 64'(o_err), 64'd0);

    // 5: out-of-range read, then overrun while a read is in flight
    read_check("t5_oor", 13'd4800, 60'd0, 2);
    check_eq("t5_err_oor", 64'(o_err), 64'd2);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 13'd5;
    n = 0; rsp_c = -1; d = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) rd_addr = 13'd7;
      if (c == 2) rd_req = 1'b0;
      if (o_rsp) begin n++; rsp_c = c; d = o_data; end
    end
    check_eq("t5_rsp_count", 64'(n), 64'd1);
    check_eq("t5_rsp_cyc", 64'(rsp_c), 64'd2);
    check_eq("t5_data", 64'(d), 64'(pat(5)));
    check_eq("t5_err_both", 64'(o_err), 64'd3);

    // 6: reset while READ; no response, outputs cleared, RAM retained
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 13'd10;
    @(negedge clk);
    @(negedge clk);
    rd_req = 1'b0; rstn = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_rsp) seen = 1;
    end
    check_eq("t6_no_rsp", 64'(seen), 64'd0);
    check_eq("t6_data_rst", 64'(o_data), 64'd0);
    check_eq("t6_err_rst", 64'(o_err), 64'd0);
    check_eq("t6_ack_rst", 64'(o_ack), 64'd0);
    rstn = 1'b1;
    read_check("t6_after_rst", 13'd10, v3, 2);

    // RD_LATENCY=2 instance
    sel = 1;
    do_write(13'd30, v6, lat);
    check_eq("l2_ack_lat", 64'(lat), 64'd2);
    read_check("l2_rd", 13'd30, v6, 3);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 13'd30;
    @(negedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_rsp) seen = 1;
    end
    check_eq("l2_no_rsp", 64'(seen), 64'd0);
    check_eq("l2_data_rst", 64'(o_data), 64'd0);
    rstn = 1'b1;
    read_check("l2_after_rst", 13'd30, v6, 3);
    do_write(13'd4800, v6, lat);
    check_eq("l2_oor_wr_ack", 64'(lat), 64'd2);
    check_eq("l2_oor_wr_err", 64'(o_err), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
